// File: rtl/vin_char_serializer.sv
// vin_char_serializer
//   Fetches one character row from the GEN over a multiplexed bus, keeps it in
//   a one-entry holding buffer, and shifts it out as pixels on pix_ce.
//
//   Ports
//     clk, rst_n                 clock, synchronous active-low reset
//     start / ready              fetch request (taken only while ready=1)
//     char_a, char_b, row        VRAM bytes and character row, sampled with start
//     sm_n, sg_n, st_n, r_wi     GEN bus strobes (st_n and r_wi are tied high)
//     adr                        row address presented to the GEN
//     bus_a_out, bus_b_out       drive data for busA/busB, bus_oe enables both
//     bus_a_in                   busA as read back from the GEN
//     pix_ce                     pixel clock enable
//     pix_on, pix_valid          current pixel and shifter-occupied flag
//     pix_fg, pix_bg             colours of the current character
//
//   Build option
//     VIN_SER_DOUBLE_WIDTH_EN    when defined, every pixel is held for 2 pix_ce.
module vin_char_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       ready,
  input  logic [7:0] char_a,
  input  logic [7:0] char_b,
  input  logic [3:0] row,
  output logic       sm_n,
  output logic       sg_n,
  output logic       st_n,
  output logic       r_wi,
  output logic [3:0] adr,
  output logic [7:0] bus_a_out,
  output logic [7:0] bus_b_out,
  output logic       bus_oe,
  input  logic [7:0] bus_a_in,
  input  logic       pix_ce,
  output logic       pix_on,
  output logic       pix_valid,
  output logic [2:0] pix_fg,
  output logic [2:0] pix_bg
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_ROW,
    S_LOAD
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;

  logic [7:0] char_a_reg, char_b_reg;
  logic [3:0] row_reg;
  logic [7:0] row_byte_reg;

  logic       buf_full_reg;
  logic [7:0] buf_byte_reg;
  logic [2:0] buf_fg_reg, buf_bg_reg;

  logic [7:0] shifter_reg;
  logic [3:0] pix_cnt_reg;   // pixels still to show, 0 = shifter empty
  logic [2:0] fg_reg, bg_reg;

  logic       accept;
  logic       last_step;     // current pix_ce finishes the current pixel
  logic       shift_load;

  assign ready  = (state_reg == S_IDLE) && !buf_full_reg;
  assign accept = (state_reg == S_IDLE) && start && ready;
  assign st_n   = 1'b1;
  assign r_wi   = 1'b1;

  // ---------------------------------------------------------------- fetch FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Strobes and bus drive decode straight from the state register, so a reset
  // edge drops any pulse in progress on that same edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sm_n       = 1'b1;
    sg_n       = 1'b1;
    bus_oe     = 1'b0;
    bus_a_out  = 8'h00;
    bus_b_out  = 8'h00;
    adr        = 4'd0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_ADDR;
          cnt_next   = 2'd0;
        end
      end
      S_ADDR: begin
        sm_n      = 1'b0;
        bus_oe    = 1'b1;
        bus_a_out = char_a_reg;
        bus_b_out = char_b_reg;
        cnt_next  = cnt_reg + 2'd1;
        if (cnt_reg == 2'd2) begin
          state_next = S_GAP;
          cnt_next   = 2'd0;
        end
      end
      S_GAP: begin
        cnt_next   = 2'd0;
        state_next = char_b_reg[7] ? S_LOAD : S_ROW;
      end
      S_ROW: begin
        sg_n     = 1'b0;
        adr      = row_reg;
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == 2'd3) begin
          state_next = S_LOAD;
          cnt_next   = 2'd0;
        end
      end
      S_LOAD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------- request and buffer data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_a_reg   <= 8'h00;
      char_b_reg   <= 8'h00;
      row_reg      <= 4'd0;
      row_byte_reg <= 8'h00;
      buf_full_reg <= 1'b0;
      buf_byte_reg <= 8'h00;
      buf_fg_reg   <= 3'd0;
      buf_bg_reg   <= 3'd0;
    end else begin
      if (accept) begin
        char_a_reg <= char_a;
        char_b_reg <= char_b;
        row_reg    <= row;
      end
      // Non-GEN characters show as a blank row.
      if (state_reg == S_GAP && char_b_reg[7])
        row_byte_reg <= 8'h00;
      if (state_reg == S_ROW && cnt_reg == 2'd3)
        row_byte_reg <= bus_a_in;
      if (shift_load)
        buf_full_reg <= 1'b0;
      // Placed after the clear: a LOAD coinciding with a shifter load leaves the
      // buffer full with the new row while the shifter takes the old one.
      if (state_reg == S_LOAD) begin
        buf_full_reg <= 1'b1;
        buf_byte_reg <= row_byte_reg;
        buf_fg_reg   <= char_a_reg[2:0];
        buf_bg_reg   <= char_a_reg[6:4];
      end
    end
  end

  // ----------------------------------------------------------------- shifter
`ifdef VIN_SER_DOUBLE_WIDTH_EN
  logic half_reg;   // 1 on the second pix_ce of a pixel

  always_ff @(posedge clk) begin
    if (!rst_n)
      half_reg <= 1'b0;
    else if (pix_ce) begin
      if (shift_load)
        half_reg <= 1'b0;
      else if (pix_cnt_reg != 4'd0)
        half_reg <= ~half_reg;
    end
  end

  assign last_step = half_reg;
`else
  assign last_step = 1'b1;
`endif

  assign shift_load = pix_ce && buf_full_reg &&
                      ((pix_cnt_reg == 4'd0) || (pix_cnt_reg == 4'd1 && last_step));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shifter_reg <= 8'h00;
      pix_cnt_reg <= 4'd0;
      fg_reg      <= 3'd0;
      bg_reg      <= 3'd0;
    end else if (pix_ce) begin
      if (shift_load) begin
        shifter_reg <= buf_byte_reg;
        pix_cnt_reg <= 4'd8;
        fg_reg      <= buf_fg_reg;
        bg_reg      <= buf_bg_reg;
      end else if (pix_cnt_reg != 4'd0 && last_step) begin
        shifter_reg <= {shifter_reg[6:0], 1'b0};
        pix_cnt_reg <= pix_cnt_reg - 4'd1;
      end
    end
  end

  assign pix_valid = (pix_cnt_reg != 4'd0);
  assign pix_on    = pix_valid && shifter_reg[7];
  assign pix_fg    = fg_reg;
  assign pix_bg    = bg_reg;

endmodule

// File: tb/tb_vin_char_serializer.sv
// Testbench for vin_char_serializer: GEN bus model, pixel scoreboard filled at
// each accepted start and drained by a pixel monitor on every pix_ce.
module tb_vin_char_serializer;

`ifdef VIN_SER_DOUBLE_WIDTH_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, ready;
  logic [7:0] char_a, char_b;
  logic [3:0] row;
  logic       sm_n, sg_n, st_n, r_wi;
  logic [3:0] adr;
  logic [7:0] bus_a_out, bus_b_out, bus_a_in;
  logic       bus_oe, pix_ce, pix_on, pix_valid;
  logic [2:0] pix_fg, pix_bg;
  logic [7:0] gen_byte;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       on;
    logic [2:0] fg;
    logic [2:0] bg;
  } pix_t;
  pix_t exp_q[$];

  always #5 clk = ~clk;

  vin_char_serializer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .char_a(char_a), .char_b(char_b), .row(row),
    .sm_n(sm_n), .sg_n(sg_n), .st_n(st_n), .r_wi(r_wi), .adr(adr),
    .bus_a_out(bus_a_out), .bus_b_out(bus_b_out), .bus_oe(bus_oe),
    .bus_a_in(bus_a_in), .pix_ce(pix_ce),
    .pix_on(pix_on), .pix_valid(pix_valid), .pix_fg(pix_fg), .pix_bg(pix_bg)
  );

  // GEN model: drives the row byte onto busA while sg_n is low.
  assign bus_a_in = !sg_n ? gen_byte : 8'hFF;

  task automatic push_char(input logic [7:0] bv, input logic [7:0] a);
    pix_t e;
    for (int i = 0; i < 8; i++) begin
      e.on = bv[7-i];
      e.fg = a[2:0];
      e.bg = a[6:4];
      for (int r = 0; r < REP; r++) exp_q.push_back(e);
    end
  endtask

  // Pixel monitor: one scoreboard entry per pix_ce while the shifter is busy.
  logic ce_seen = 1'b0;
  always @(posedge clk) ce_seen <= pix_ce;

  always @(negedge clk) begin
    pix_t e;
    if (ce_seen && pix_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got pixel on=%0d fg=%0d bg=%0d, required none", pix_on, pix_fg, pix_bg);
      end else begin
        e = exp_q.pop_front();
        if ({pix_on, pix_fg, pix_bg} !== {e.on, e.fg, e.bg})
          $display("FAIL sb_pixel: got on=%0d fg=%0d bg=%0d, required on=%0d fg=%0d bg=%0d",
                   pix_on, pix_fg, pix_bg, e.on, e.fg, e.bg);
        else passed++;
      end
    end else if (ce_seen && !pix_valid) begin
      checks++;
      if (pix_on !== 1'b0) $display("FAIL blank_on: got pix_on=%0d, required 0", pix_on);
      else passed++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sm_n, sg_n, st_n, r_wi, bus_oe} !== 5'b11110)
      $display("FAIL rst_strobes: got %b, required 11110", {sm_n, sg_n, st_n, r_wi, bus_oe});
    else passed++;
    checks++;
    if ({adr, bus_a_out, bus_b_out} !== 20'h0)
      $display("FAIL rst_bus: got adr=%0h a=%0h b=%0h, required 0", adr, bus_a_out, bus_b_out);
    else passed++;
    checks++;
    if ({pix_on, pix_valid, pix_fg, pix_bg} !== 8'h00)
      $display("FAIL rst_pix: got %b, required 0", {pix_on, pix_valid, pix_fg, pix_bg});
    else passed++;
    checks++;
    if (ready !== 1'b1) $display("FAIL rst_ready: got %0d, required 1", ready);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One fetch with pix_ce held high; checks strobe timing, latency and drain.
  task automatic test_fetch(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] r, input logic [7:0] gb);
    int sm_low = 0, sg_low = 0, first_sg = -1, first_valid = -1;
    bit adr_ok = 1'b1;
    int exp_lat;
    pix_ce = 1'b1;
    @(negedge clk);
    char_a = a; char_b = b; row = r; gen_byte = gb; start = 1'b1;
    push_char(b[7] ? 8'h00 : gb, a);
    $display("fetch a=%02h b=%02h row=%0d gen=%02h", a, b, r, gb);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (!sm_n) sm_low++;
      if (!sg_n) begin
        sg_low++;
        if (first_sg < 0) first_sg = j;
        if (adr !== r) adr_ok = 1'b0;
      end
      if (pix_valid && first_valid < 0) first_valid = j;
    end
    exp_lat = b[7] ? 6 : 10;
    checks++;
    if (sm_low != 3) $display("FAIL sm_width: got %0d cycles, required 3", sm_low);
    else passed++;
    checks++;
    if (sg_low != (b[7] ? 0 : 4)) $display("FAIL sg_width: got %0d cycles, required %0d", sg_low, b[7] ? 0 : 4);
    else passed++;
    if (!b[7]) begin
      checks++;
      if (first_sg != 4 || !adr_ok) $display("FAIL sg_start_adr: got start=%0d adr_ok=%0d, required 4/1", first_sg, adr_ok);
      else passed++;
    end
    checks++;
    if (first_valid != exp_lat) $display("FAIL latency: got %0d, required %0d", first_valid, exp_lat);
    else passed++;
    checks++;
    if (exp_q.size() != 0 || pix_valid !== 1'b0) $display("FAIL drain: got left=%0d valid=%0d, required 0/0", exp_q.size(), pix_valid);
    else passed++;
    checks++;
    if ({pix_fg, pix_bg} !== {a[2:0], a[6:4]}) $display("FAIL colour_hold: got fg=%0d bg=%0d, required %0d %0d", pix_fg, pix_bg, a[2:0], a[6:4]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[3] = '{8'h47, 8'h12, 8'h63};
    logic [7:0] tb_[3] = '{8'h21, 8'h80, 8'h85};
    int n_acc = 0, run = 0;
    bit seen = 1'b0, ended = 1'b0;
    pix_ce = 1'b1;
    gen_byte = 8'hA5;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (ready && n_acc < 3) begin
        char_a = ta[n_acc]; char_b = tb_[n_acc]; row = 4'd5; start = 1'b1;
        push_char(tb_[n_acc][7] ? 8'h00 : gen_byte, ta[n_acc]);
        $display("b2b start %0d a=%02h b=%02h", n_acc, ta[n_acc], tb_[n_acc]);
        n_acc++;
      end else start = 1'b0;
      if (pix_valid) begin
        seen = 1'b1;
        if (!ended) run++;
      end else if (seen) ended = 1'b1;
    end
    checks++;
    if (n_acc != 3) $display("FAIL b2b_accepts: got %0d, required 3", n_acc);
    else passed++;
    checks++;
    if (run != 24 * REP) $display("FAIL b2b_gapless: got %0d valid cycles, required %0d", run, 24 * REP);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_start_held();
    int falls = 0, low = 0;
    logic prev = 1'b1;
    pix_ce = 1'b0;
    @(negedge clk);
    char_a = 8'h35; char_b = 8'h80; row = 4'd1; start = 1'b1;
    push_char(8'h00, 8'h35);
    $display("held start a=35 b=80");
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (!sm_n) low++;
      if (prev && !sm_n) falls++;
      prev = sm_n;
    end
    checks++;
    if (falls != 1 || low != 3) $display("FAIL held_sm: got pulses=%0d low=%0d, required 1/3", falls, low);
    else passed++;
    checks++;
    if (ready !== 1'b0) $display("FAIL held_ready: got %0d, required 0", ready);
    else passed++;
    start = 1'b0;
    pix_ce = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL held_drain: got %0d left, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    int hits = 0;
    pix_ce = 1'b1;
    @(negedge clk);
    char_a = 8'h51; char_b = 8'h80; row = 4'd0; start = 1'b1;
    push_char(8'h00, 8'h51);
    $display("mid-fetch reset: preload a=51");
    for (int j = 0; j < 20 && !pix_valid; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    pix_ce = 1'b0;
    checks++;
    if (pix_valid !== 1'b1) $display("FAIL mf_busy: got pix_valid=%0d, required 1", pix_valid);
    else passed++;
    char_a = 8'h47; char_b = 8'h21; row = 4'd3; gen_byte = 8'hA5; start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
    end
    checks++;
    if (sg_n !== 1'b0) $display("FAIL mf_in_row: got sg_n=%0d, required 0", sg_n);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({sg_n, sm_n, bus_oe, ready, pix_valid} !== 5'b11010)
      $display("FAIL mf_after_rst: got sg,sm,oe,ready,valid=%b, required 11010", {sg_n, sm_n, bus_oe, ready, pix_valid});
    else passed++;
    rst_n = 1'b1;
    exp_q.delete();
    pix_ce = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (pix_valid) hits++;
    end
    checks++;
    if (hits != 0) $display("FAIL mf_discard: got %0d valid cycles, required 0", hits);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_ce = 1'b0;
    char_a = 8'h00; char_b = 8'h00; row = 4'd0; gen_byte = 8'h00;
    test_reset();
    test_fetch(8'h47, 8'h21, 4'd3, 8'hA5);
    test_fetch(8'h30, 8'h80, 4'd0, 8'h5A);
    test_fetch(8'h02, 8'h05, 4'd9, 8'h80);
    test_fetch(8'h7F, 8'h00, 4'd0, 8'h01);
    test_back_to_back();
    test_start_held();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
